// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin, packet-locking write arbiter feeding a synchronous FIFO
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 64,
    localparam int LW    = $clog2(DEPTH) + 1,
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         i_req_valid,
    input  logic [NREQ*WIDTH-1:0]   i_req_data,
    input  logic [NREQ-1:0]         i_req_last,
    output logic [NREQ-1:0]         o_req_ready,
    output logic                    o_fifo_we,
    output logic [WIDTH-1:0]        o_fifo_wdata,
    input  logic                    i_fifo_re,
    input  logic                    i_fifo_empty,
    output logic [LW-1:0]           o_level,
    output logic [NREQ-1:0]         o_owner
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_own_idx;

    logic            w_win_found;
    logic [PW-1:0]   w_win_idx;
    logic [PW-1:0]   w_sel_idx;
    logic [PW-1:0]   w_ptr_next;
    logic            w_space;
    logic            w_accept;
    logic            w_pop;
    logic            w_sel_last;
    logic [WIDTH-1:0] w_sel_data;

    // Scan from the highest offset down so the candidate closest to r_ptr wins.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            logic [PW-1:0] cand;
            cand = PW'((int'(r_ptr) + k) % NREQ);
            if (i_req_valid[cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = cand;
            end
        end
    end

    // Conservative space: a pop in this same cycle does not free a slot.
    assign w_space    = (o_level < LW'(DEPTH));
    assign w_sel_idx  = (r_state == S_LOCK) ? r_own_idx : w_win_idx;
    assign w_ptr_next = (w_sel_idx == PW'(NREQ - 1)) ? '0 : w_sel_idx + PW'(1);
    assign w_sel_data = i_req_data[int'(w_sel_idx)*WIDTH +: WIDTH];
    assign w_sel_last = i_req_last[w_sel_idx];

    always_comb begin
        o_req_ready = '0;
        if (!rst && w_space) begin
            if (r_state == S_LOCK) begin
                o_req_ready = o_owner;
            end else if (w_win_found) begin
                o_req_ready[w_win_idx] = 1'b1;
            end
        end
    end

    assign w_accept = |(i_req_valid & o_req_ready);
    assign w_pop    = i_fifo_re && !i_fifo_empty && (o_level != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_own_idx    <= '0;
            o_owner      <= '0;
            o_level      <= '0;
            o_fifo_we    <= 1'b0;
            o_fifo_wdata <= '0;
        end else begin
            o_fifo_we <= w_accept;
            if (w_accept) begin
                o_fifo_wdata <= w_sel_data;
            end

            case ({w_accept, w_pop})
                2'b10:   o_level <= o_level + LW'(1);
                2'b01:   o_level <= o_level - LW'(1);
                default: o_level <= o_level;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_sel_last) begin
                            r_ptr <= w_ptr_next;
                        end else begin
                            r_state   <= S_LOCK;
                            o_owner   <= o_req_ready;
                            r_own_idx <= w_win_idx;
                        end
                    end
                end
                S_LOCK: begin
                    if (w_accept && w_sel_last) begin
                        r_state <= S_IDLE;
                        o_owner <= '0;
                        r_ptr   <= w_ptr_next;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Scoreboard bench for fifo_wr_arbiter against a queue-based model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       i_req_valid = '0;
    logic [NREQ*WIDTH-1:0] i_req_data  = '0;
    logic [NREQ-1:0]       i_req_last  = '0;
    logic [NREQ-1:0]       o_req_ready;
    logic                  o_fifo_we;
    logic [WIDTH-1:0]      o_fifo_wdata;
    logic                  i_fifo_re    = 1'b0;
    logic                  i_fifo_empty = 1'b1;
    logic [LW-1:0]         o_level;
    logic [NREQ-1:0]       o_owner;

    int errors = 0;
    int checks = 0;

    // Reference model state: lock holder (-1 = none), round-robin start, occupancy.
    int m_lock = -1;
    int m_ptr  = 0;
    int m_lvl  = 0;
    logic [WIDTH-1:0] sb[$];

    fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .i_req_data   (i_req_data),
        .i_req_last   (i_req_last),
        .o_req_ready  (o_req_ready),
        .o_fifo_we    (o_fifo_we),
        .o_fifo_wdata (o_fifo_wdata),
        .i_fifo_re    (i_fifo_re),
        .i_fifo_empty (i_fifo_empty),
        .o_level      (o_level),
        .o_owner      (o_owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every FIFO write must match the oldest accepted beat.
    always @(posedge clk) begin
        #1;
        if (o_fifo_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got data %0h expected no write", o_fifo_wdata);
            end else begin
                logic [WIDTH-1:0] e;
                e = sb.pop_front();
                chk("wdata", 64'(o_fifo_wdata), 64'(e));
            end
        end
    end

    // Drive one cycle at the negedge, check against the model, advance the model.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                        input logic re, input logic emp);
        logic [NREQ-1:0] exp_rdy;
        int g;
        int pop;
        int acc;
        i_req_valid  = v;
        i_req_last   = l;
        i_fifo_re    = re;
        i_fifo_empty = emp;
        for (int i = 0; i < NREQ; i++) i_req_data[i*WIDTH +: WIDTH] = $urandom();
        #1;
        chk("write_latency", 64'(sb.size()), 64'd0);
        exp_rdy = '0;
        g = -1;
        if (m_lock >= 0) begin
            g = m_lock;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        if (g >= 0 && m_lvl < DEPTH) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(o_req_ready), 64'(exp_rdy));
        chk("level", 64'(o_level), 64'(m_lvl));
        chk("owner", 64'(o_owner), (m_lock >= 0) ? (64'd1 << m_lock) : 64'd0);
        acc = ((v & exp_rdy) != '0) ? 1 : 0;
        if (acc == 1) begin
            sb.push_back(i_req_data[g*WIDTH +: WIDTH]);
            if (l[g]) begin
                m_lock = -1;
                m_ptr  = (g + 1) % NREQ;
            end else begin
                m_lock = g;
            end
        end
        pop = (re && !emp && m_lvl > 0) ? 1 : 0;
        m_lvl = m_lvl + acc - pop;
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle and checks the asynchronous clear before any edge.
    task automatic do_reset();
        #2;
        i_req_valid = '1;
        rst = 1'b1;
        #1;
        chk("rst_ready", 64'(o_req_ready), 64'd0);
        chk("rst_we", 64'(o_fifo_we), 64'd0);
        chk("rst_wdata", 64'(o_fifo_wdata), 64'd0);
        chk("rst_level", 64'(o_level), 64'd0);
        chk("rst_owner", 64'(o_owner), 64'd0);
        sb.delete();
        m_lock = -1;
        m_ptr  = 0;
        m_lvl  = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // All four requesters with single-beat packets: grants rotate 0..3.
        repeat (4) step(4'hF, 4'hF, 1'b0, 1'b1);
        chk("lvl_after_rr", 64'(o_level), 64'd4);

        // Multi-beat lock by req0 while req1 waits.
        do_reset();
        step(4'b0011, 4'b0000, 1'b0, 1'b1);
        step(4'b0011, 4'b0000, 1'b0, 1'b1);
        chk("lock_owner", 64'(o_owner), 64'b0001);
        step(4'b0011, 4'b0001, 1'b0, 1'b1);
        chk("unlock_owner", 64'(o_owner), 64'd0);
        step(4'b0011, 4'b0011, 1'b0, 1'b1);

        // Fill to DEPTH, back-pressure, then one pop reopens space a cycle later.
        do_reset();
        repeat (DEPTH) step(4'b0001, 4'b0001, 1'b0, 1'b0);
        chk("full_level", 64'(o_level), 64'(DEPTH));
        step(4'b0001, 4'b0001, 1'b0, 1'b0);
        step(4'b0001, 4'b0001, 1'b1, 1'b0);
        chk("after_pop", 64'(o_level), 64'(DEPTH - 1));
        step(4'b0001, 4'b0001, 1'b0, 1'b0);

        // Simultaneous accept and pop; pop while empty is ignored.
        do_reset();
        repeat (10) step(4'b0010, 4'b0010, 1'b0, 1'b0);
        step(4'b0010, 4'b0010, 1'b1, 1'b0);
        chk("acc_pop_level", 64'(o_level), 64'd10);
        step(4'b0000, 4'b0000, 1'b1, 1'b1);
        chk("empty_pop_level", 64'(o_level), 64'd10);

        // Reset in the middle of req2's packet, then arbitration restarts at 0.
        do_reset();
        repeat (4) step(4'b0100, 4'b0100, 1'b0, 1'b0);
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        chk("pre_rst_owner", 64'(o_owner), 64'b0100);
        chk("pre_rst_level", 64'(o_level), 64'd5);
        do_reset();
        step(4'b1010, 4'b1010, 1'b0, 1'b1);

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [NREQ-1:0] rv;
            logic [NREQ-1:0] rl;
            logic            rre;
            logic            remp;
            rv   = NREQ'($urandom());
            rl   = NREQ'($urandom() | $urandom());
            rre  = ($urandom_range(0, 2) == 0);
            remp = (m_lvl == 0) || ($urandom_range(0, 7) == 0);
            step(rv, rl, rre, remp);
        end
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of write requesters.
REQ-002 SHALL have parameter WIDTH, default 32: data word width.
REQ-003 SHALL have parameter DEPTH, default 64: capacity of the downstream synchronous FIFO (power of two); LW = $clog2(DEPTH)+1.
REQ-004 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: req_valid  input  NREQ  per-requester beat valid.
REQ-007 SHALL have port: req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port: req_last  input  NREQ  per-requester last beat of packet.
REQ-009 SHALL have port: req_ready  output  NREQ  combinational accept; at most one bit set.
REQ-010 SHALL have port: fifo_we  output  1  registered FIFO write enable.
REQ-011 SHALL have port: fifo_wdata  output  WIDTH  registered FIFO write data.
REQ-012 SHALL have port: fifo_re  input  1  FIFO read enable as driven by the consumer.
REQ-013 SHALL have port: fifo_empty  input  1  FIFO empty flag; pop occurs when fifo_re && !fifo_empty.
REQ-014 SHALL have port: level  output  LW  registered occupancy count tracked by this block.
REQ-015 SHALL have port: owner  output  NREQ  registered one-hot lock holder; 0 when unlocked.

Function
REQ-016 SHALL implement two states: IDLE (no lock) and LOCK (owner holds grant until its last beat).
REQ-017 SHALL define space = (level < DEPTH); a same-cycle pop does not create space (conservative).
REQ-018 SHALL in IDLE select winner = first i with req_valid[i], searching ptr, ptr+1, ... modulo NREQ.
REQ-019 SHALL in IDLE assert req_ready[winner] iff space; all other bits 0.
REQ-020 SHALL in LOCK assert req_ready[owner] iff space (regardless of owner's req_valid); all others 0.
REQ-021 SHALL define accept = |(req_valid & req_ready).
REQ-022 SHALL on accept register fifo_we=1 and fifo_wdata=accepted data next cycle (latency 1); else fifo_we=0, fifo_wdata holds.
REQ-023 SHALL transition IDLE->LOCK on accept with req_last=0, setting owner=one-hot(winner).
REQ-024 SHALL remain IDLE on accept with req_last=1 (single-beat packet) and set ptr=winner+1 mod NREQ.
REQ-025 SHALL transition LOCK->IDLE on accept of owner's beat with req_last=1, setting owner=0 and ptr=owner index+1 mod NREQ.
REQ-026 SHALL leave ptr unchanged when no packet completes.
REQ-027 SHALL update level: +1 on accept only, -1 on pop only, unchanged on both or neither.
REQ-028 SHALL never decrement level below 0 (pop with level==0 ignored) nor exceed DEPTH.
REQ-029 SHALL keep LOCK with no ready issued while level==DEPTH; other requesters remain blocked.

Reset
REQ-030 SHALL on rst asynchronously set state=IDLE, ptr=0, owner=0, level=0, fifo_we=0, fifo_wdata=0.
REQ-031 SHALL force req_ready=0 while rst is asserted.
REQ-032 SHALL abandon any packet in progress on reset mid-LOCK; first post-reset accept arbitrates from ptr=0.

Verification
REQ-033 SHALL verify: reset, req_valid=4'b1111 all req_last=1 for 4 cycles, no pops -> grants 0,1,2,3 in order, fifo_we high cycles 2-5, level=4.
REQ-034 SHALL verify: req0 sends 3-beat packet (last on beat 3) while req1 valid -> req_ready=4'b0001 for 3 cycles, owner=4'b0001 then 0, next grant to req1.
REQ-035 SHALL verify: write 64 single beats, no pops -> level=64, req_ready=0; one pop -> level=63, ready returns next cycle.
REQ-036 SHALL verify: level=10, accept and pop same cycle -> level stays 10; pop with fifo_empty=1 -> level unchanged.
REQ-037 SHALL verify: rst asserted mid-LOCK (owner=4'b0100, level=5) -> owner=0, level=0, fifo_we=0 immediately; next grant to lowest valid index from 0.
